evm_ballot_ctrl: RTL
====================

// Module: evm_ballot_ctrl
// PURPOSE
//  Parametrised ballot controller for the EVM: N_CAND one-hot choices (last index = NOTA),
//  officer-armed single-vote handshake, saturating per-candidate tallies, running total,
//  timed confirmation LEDs, and a sequential winner/tie scan on poll close.
//  Sits between the ballot-unit switch debouncer and the result display/readout logic.
// PARAMETERS
//  N_CAND    5  number of choices incl. NOTA (>=3); index N_CAND-1 is NOTA
//  CNT_W     8  width of each per-candidate tally
//  LED_HOLD  2  cycles pled[i] stays high after an accepted vote (>=1)
// PORTS
//  clk          in   1                   system clock, rising edge
//  rst          in   1                   asynchronous reset, active-high
//  session_en   in   1                   poll open request (level)
//  ballot_arm   in   1                   officer enables exactly one ballot
//  close        in   1                   poll close request (1-cycle pulse or level)
//  vo_valid     in   1                   voter presses cast
//  vo_switch    in   N_CAND              choice, must be one-hot
//  tally_sel    in   $clog2(N_CAND)      tally readout select
//  vo_ready     out  1                   ballot armed, vote will be accepted
//  tally        out  CNT_W               count of candidate tally_sel (0 if sel>=N_CAND)
//  total        out  CNT_W+$clog2(N_CAND) sum of all tallies
//  pled         out  N_CAND              per-choice confirmation LEDs
//  invalid      out  1                   1-cycle pulse: non-one-hot cast rejected
//  overflow     out  1                   sticky: some tally hit saturation
//  winner       out  $clog2(N_CAND)      winning candidate index (NOTA excluded)
//  tie          out  1                   >1 candidate shares max count
//  result_valid out  1                   winner/tie valid
// BEHAVIOUR
//  Reset (async, any state): all outputs 0, tallies/total/timers 0, state IDLE.
//  States IDLE, LOCK, ARMED, SCAN, DONE; all transitions on rising clk.
//  IDLE : session_en=1 -> clear tallies, total, overflow, winner, tie, pled; go LOCK.
//  LOCK : vo_ready=0. close=1 -> SCAN (priority); else ballot_arm=1 -> ARMED.
//  ARMED: vo_ready=1 (registered, asserted cycle after arm). vo_valid=1:
//   - vo_switch one-hot (index i): tally[i]+1, total+1, pled[i] loaded; go LOCK.
//   - otherwise: invalid=1 for exactly one cycle, no count change, stay ARMED.
//   close=1 -> SCAN; overrides a same-cycle vo_valid (ballot discarded, no count).
//  vo_valid outside ARMED is ignored (no invalid pulse).
//  Tally rule: if tally[i]==2^CNT_W-1, tally and total hold, overflow set and held
//   until next IDLE->LOCK; the ballot is still consumed (go LOCK). total never wraps.
//  Tally/total update is visible the cycle after the accepting edge.
//  pled: accept at edge k -> pled[i]=1 for exactly LED_HOLD cycles after k; revote of
//   same index reloads its timer; LEDs are independent; LED timers keep running in
//   SCAN/DONE and are cleared on session open.
//  SCAN : one candidate per cycle, indices 0..N_CAND-2 (NOTA excluded), takes
//   N_CAND-1 cycles; strictly greater count replaces best; equal count sets tie;
//   lowest index wins ties. All-zero tallies -> winner=0, tie=1.
//  DONE : result_valid=1, winner/tie/tallies held; session_en=0 -> IDLE
//   (results retained until next open). result_valid drops on leaving DONE.
//  session_en falling in LOCK/ARMED has no effect; only close ends a poll.
//  tally readout is combinational on tally_sel, valid in every state.
// TESTING
//  1 Reset mid-ARMED with vo_ready=1 -> next cycle all outputs 0, state IDLE, vo_ready=0.
//  2 N_CAND=5: open, arm+cast 00001, 00100, 00100, 10000 -> tally[0]=1, tally[2]=2,
//    tally[4]=1, total=4; pled[2] high exactly 2 cycles after each accept.
//  3 Armed cast of 00011 and 00000 -> invalid pulses 1 cycle each, total unchanged,
//    vo_ready stays 1; next cast 01000 accepted, tally[3]=1.
//  4 CNT_W=2: four votes for index 1 -> tally[1]=3, total=3, overflow=1; close ->
//    winner=1, tie=0, result_valid after 4 SCAN cycles.
//  5 Tallies {2,2,1,0,NOTA=5} then close -> winner=0, tie=1 (NOTA ignored).
//  6 close and vo_valid same cycle in ARMED -> no tally change, state SCAN; zero votes
//    -> winner=0, tie=1.

Source files
------------

// File: rtl/evm_ballot_ctrl.sv
// EVM ballot controller: armed single-vote handshake, saturating tallies, confirmation LEDs,
// and a sequential winner/tie scan once the poll closes.

module evm_led_timer #(
    parameter int LED_HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    output logic on
);
    localparam int TW = $clog2(LED_HOLD + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (clr)           cnt <= '0;
        else if (load)          cnt <= TW'(LED_HOLD);
        else if (cnt != '0)     cnt <= cnt - TW'(1);
    end

    assign on = (cnt != '0);
endmodule

module evm_ballot_ctrl #(
    parameter int N_CAND   = 5,
    parameter int CNT_W    = 8,
    parameter int LED_HOLD = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             session_en,
    input  logic                             ballot_arm,
    input  logic                             close,
    input  logic                             vo_valid,
    input  logic [N_CAND-1:0]                vo_switch,
    input  logic [$clog2(N_CAND)-1:0]        tally_sel,
    output logic                             vo_ready,
    output logic [CNT_W-1:0]                 tally,
    output logic [CNT_W+$clog2(N_CAND)-1:0]  total,
    output logic [N_CAND-1:0]                pled,
    output logic                             invalid,
    output logic                             overflow,
    output logic [$clog2(N_CAND)-1:0]        winner,
    output logic                             tie,
    output logic                             result_valid
);
    localparam int SEL_W = $clog2(N_CAND);
    localparam int TOT_W = CNT_W + SEL_W;

    typedef enum logic [2:0] {IDLE, LOCK, ARMED, SCAN, DONE} state_t;

    state_t                        state, state_nx;
    logic [N_CAND-1:0][CNT_W-1:0]  tallies;
    logic [CNT_W-1:0]              best;
    logic [SEL_W-1:0]              scan_idx;
    logic [SEL_W-1:0]              sel_idx;
    logic [CNT_W-1:0]              cur;
    logic                          onehot, open, accept, reject, sat;

    assign onehot = (vo_switch != '0) && ((vo_switch & (vo_switch - N_CAND'(1))) == '0);
    assign open   = (state == IDLE) && session_en;
    // close wins over a same-cycle cast: the ballot is simply dropped
    assign accept = (state == ARMED) && vo_valid && !close && onehot;
    assign reject = (state == ARMED) && vo_valid && !close && !onehot;
    assign sat    = (tallies[sel_idx] == '1);
    assign cur    = tallies[scan_idx];

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_CAND; i++)
            if (vo_switch[i]) sel_idx = SEL_W'(i);
    end

    always_comb begin
        tally = '0;
        for (int i = 0; i < N_CAND; i++)
            if (tally_sel == SEL_W'(i)) tally = tallies[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (session_en) state_nx = LOCK;
            LOCK:    if (close) state_nx = SCAN;
                     else if (ballot_arm) state_nx = ARMED;
            ARMED:   if (close) state_nx = SCAN;
                     else if (accept) state_nx = LOCK;
            SCAN:    if (scan_idx == SEL_W'(N_CAND - 2)) state_nx = DONE;
            DONE:    if (!session_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        result_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tallies  <= '0;
            total    <= '0;
            overflow <= 1'b0;
            winner   <= '0;
            tie      <= 1'b0;
            best     <= '0;
            scan_idx <= '0;
            vo_ready <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            vo_ready <= (state_nx == ARMED);
            invalid  <= reject;
            if (open) begin
                tallies  <= '0;
                total    <= '0;
                overflow <= 1'b0;
                winner   <= '0;
                tie      <= 1'b0;
            end
            if (accept) begin
                if (sat) overflow <= 1'b1;
                else begin
                    tallies[sel_idx] <= tallies[sel_idx] + CNT_W'(1);
                    total            <= total + TOT_W'(1);
                end
            end
            if (state != SCAN && state_nx == SCAN) begin
                scan_idx <= '0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + SEL_W'(1);
                // NOTA sits at the top index and is never visited
                if (scan_idx == '0) begin
                    winner <= '0;
                    best   <= cur;
                    tie    <= 1'b0;
                end else if (cur > best) begin
                    winner <= scan_idx;
                    best   <= cur;
                    tie    <= 1'b0;
                end else if (cur == best) begin
                    tie <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CAND; g++) begin : g_led
        evm_led_timer #(.LED_HOLD(LED_HOLD)) u_led (
            .clk  (clk),
            .rst  (rst),
            .clr  (open),
            .load (accept && (sel_idx == SEL_W'(g))),
            .on   (pled[g])
        );
    end
endmodule
